// File: rtl/seq_scan_ctrl_if.sv
// Handshake and result bundle between a word producer (master) and the
// serial pattern-scan controller (slave).
interface seq_scan_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       pattern;
  logic             busy;
  logic             done;
  logic             match;
  logic             found;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] first_pos;

  modport master (
    output start, abort, data_in, pattern,
    input  busy, done, match, found, match_cnt, first_pos
  );

  modport slave (
    input  start, abort, data_in, pattern,
    output busy, done, match, found, match_cnt, first_pos
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Latches a word and a 4-bit pattern, shifts the word MSB-first through a
// 4-bit detection window, and reports per-bit matches plus a final summary.
module seq_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  seq_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] shreg;
  logic [3:0]       pat;
  logic [2:0]       hist;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] first_pos;
  logic             found;
  logic             match;
  logic             busy;
  logic             done;

  logic             bit_in;
  logic             last_bit;
  logic             hit;
  logic             accept;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    bit_in     = shreg[WIDTH-1];
    last_bit   = (idx == CNT_W'(WIDTH - 1));
    hit        = (state == SHIFT) && !bus.abort && (idx >= CNT_W'(3)) &&
                 ({hist, bit_in} == pat);
    // The DONE->IDLE edge also accepts, giving one word per WIDTH+1 cycles.
    accept     = ((state == IDLE) || (state == DONE)) && bus.start && !bus.abort;
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT: begin
        if (bus.abort)     next_state = IDLE;
        else if (last_bit) next_state = DONE;
      end
      DONE:    next_state = accept ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      pat       <= '0;
      hist      <= '0;
      idx       <= '0;
      match_cnt <= '0;
      first_pos <= '0;
      found     <= 1'b0;
      match     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy  <= (next_state == SHIFT);
      done  <= (next_state == DONE);
      match <= hit;
      if (accept) begin
        shreg     <= bus.data_in;
        pat       <= bus.pattern;
        hist      <= '0;
        idx       <= '0;
        match_cnt <= '0;
        first_pos <= '0;
        found     <= 1'b0;
      end else if ((state == SHIFT) && !bus.abort) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        hist  <= {hist[1:0], bit_in};
        idx   <= idx + CNT_W'(1);
        if (hit) begin
          match_cnt <= match_cnt + CNT_W'(1);
          found     <= 1'b1;
          if (!found) first_pos <= idx;
        end
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.match     = match;
  assign bus.found     = found;
  assign bus.match_cnt = match_cnt;
  assign bus.first_pos = first_pos;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: the driver queues expected match/done
// events with their edge numbers, a negedge monitor pops and compares them.
module tb_seq_scan_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  typedef struct {
    bit is_done;
    int at;
    int cnt;
    int first;
    bit found;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   busy_run = 0;
  exp_t exp_q[$];

  seq_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops one expected record per presented match or done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy) busy_run++;
    if (bus.match) begin
      if (exp_q.size() == 0) check("unexpected_match", bus.match, 0);
      else begin
        e = exp_q.pop_front();
        check("match_kind", 32'(e.is_done), 0);
        check("match_edge", cyc, e.at);
      end
    end
    if (bus.done) begin
      if (exp_q.size() == 0) check("unexpected_done", bus.done, 0);
      else begin
        e = exp_q.pop_front();
        check("done_kind", 32'(e.is_done), 1);
        check("done_edge", cyc, e.at);
        check("done_match_cnt", bus.match_cnt, e.cnt);
        check("done_first_pos", bus.first_pos, e.first);
        check("done_found", bus.found, e.found);
        check("done_busy_low", bus.busy, 0);
        check("busy_cycles", busy_run, WIDTH);
      end
      busy_run = 0;
    end
    if (!bus.busy && !bus.done) busy_run = 0;
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] data, input logic [3:0] pat, output int e0);
    bus.data_in = data;
    bus.pattern = pat;
    bus.start   = 1'b1;
    e0          = cyc + 1;
  endtask

  task automatic push_scan(input int e0, input logic [WIDTH-1:0] mask, input int cnt, input int first);
    exp_t e;
    for (int k = 0; k < WIDTH; k++) begin
      if (mask[k]) begin
        e.is_done = 1'b0; e.at = e0 + k + 1; e.cnt = 0; e.first = 0; e.found = 1'b0;
        exp_q.push_back(e);
      end
    end
    e.is_done = 1'b1; e.at = e0 + WIDTH; e.cnt = cnt; e.first = first; e.found = (cnt != 0);
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_match"}, bus.match, 0);
    check({tag, "_found"}, bus.found, 0);
    check({tag, "_match_cnt"}, bus.match_cnt, 0);
    check({tag, "_first_pos"}, bus.first_pos, 0);
  endtask

  // mask bit k set means a match is expected on bit index k (0 = MSB).
  task automatic run_scan(input logic [WIDTH-1:0] data, input logic [3:0] pat,
                          input logic [WIDTH-1:0] mask, input int cnt, input int first);
    int e0;
    issue(data, pat, e0);
    push_scan(e0, mask, cnt, first);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(e0 + WIDTH + 3);
    check("scan_drain", exp_q.size(), 0);
    check("held_match_cnt", bus.match_cnt, cnt);
    check("held_first_pos", bus.first_pos, first);
  endtask

  initial begin
    int   e0;
    exp_t e;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.data_in = '0;
    bus.pattern = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid-scan: scan dies silently, outputs cleared.
    issue(16'hA5A5, 4'b1010, e0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(e0 + 2);
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(e0 + WIDTH + 4);
    check("midreset_drain", exp_q.size(), 0);
    check("midreset_idle", bus.busy, 0);

    // Basic, overlap and window-boundary scans.
    run_scan(16'hA5A5, 4'b1010, 16'h0808, 2, 3);
    run_scan(16'hAAAA, 4'b1010, 16'hAAA8, 7, 3);
    run_scan(16'h0000, 4'b0000, 16'hFFF8, 13, 3);
    run_scan(16'hFFFF, 4'b1010, 16'h0000, 0, 0);

    // Handshake: start held high; second accept at E0+WIDTH+1; pattern
    // changes during each scan must not matter.
    issue(16'hA5A5, 4'b1010, e0);
    push_scan(e0, 16'h0808, 2, 3);
    push_scan(e0 + WIDTH + 1, 16'h0808, 2, 3);
    wait_cyc(e0 + 5);
    bus.pattern = 4'b0000;
    wait_cyc(e0 + 14);
    bus.pattern = 4'b1010;
    wait_cyc(e0 + WIDTH + 1);
    bus.start = 1'b0;
    wait_cyc(e0 + WIDTH + 6);
    bus.pattern = 4'b0101;
    wait_cyc(e0 + 2 * WIDTH + 4);
    check("handshake_drain", exp_q.size(), 0);
    check("handshake_cnt", bus.match_cnt, 2);

    // Abort before the bit-5 hit: partial results kept, no done, no pulse.
    issue(16'hAAAA, 4'b1010, e0);
    e.is_done = 1'b0; e.at = e0 + 4; e.cnt = 0; e.first = 0; e.found = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(e0 + 5);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_match", bus.match, 0);
    check("abort_match_cnt", bus.match_cnt, 1);
    check("abort_first_pos", bus.first_pos, 3);
    check("abort_found", bus.found, 1);
    wait_cyc(e0 + WIDTH + 4);
    check("abort_drain", exp_q.size(), 0);
    check("abort_held_cnt", bus.match_cnt, 1);

    // Abort in IDLE blocks a simultaneous start.
    bus.data_in = 16'h0000;
    bus.pattern = 4'b0000;
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("idle_abort_busy", bus.busy, 0);
    check("idle_abort_cnt", bus.match_cnt, 1);
    repeat (3) @(negedge clk);
    check("idle_abort_still_idle", bus.busy, 0);
    check("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
